// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and alignment helpers for mem_access_unit
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } mem_state_t;

  // Encoding 2'b11 is not a legal size and is handled exactly like a word.
  function automatic logic is_word(input logic [1:0] size);
    return (size != SZ_BYTE) && (size != SZ_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extraction, sign/zero extension and store merge
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        signed_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lanes out of the RAM word and build both the load result and the merged store word.
  always_comb begin
    load_data  = rdata;
    merge_data = wdata;
    sel_byte   = rdata[{addr_lo, 3'b000} +: 8];
    sel_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{signed_ext & sel_byte[7]}}, sel_byte};
        merge_data = rdata;
        merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{signed_ext & sel_half[15]}}, sel_half};
        merge_data = rdata;
        merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store to word-only RAM bridge; MEM_MISALIGN_CHECK_EN enables misalignment errors
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  mem_state_t  state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        misaligned;
  logic        unused_addr_hi;

  // Address bits beyond the RAM window have no effect on the access.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);

  // Lanes are computed from the live RAM output so WAIT can commit load/merge results directly.
  mem_lane_align u_lane_align (
    .size       (size_q),
    .addr_lo    (addr_lo_q),
    .signed_ext (signed_q),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Transaction FSM: all RAM and response outputs are registered and driven on state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      write_q   <= 1'b0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= 32'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[ADDR_W+1:2];
            if (misaligned) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_write && is_word(req_size)) begin
              state     <= ST_WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (write_q) begin
            state     <= ST_WR;
            mem_we    <= 1'b1;
            mem_wdata <= merge_data;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        ST_WR: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a behavioural word RAM
module tb_mem_access_unit;

  localparam int ADDR_W = 14;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  int                total = 0;
  int                bad = 0;
  int                we_count = 0;
  int                rsp_count = 0;
  int                acc_count = 0;
  logic [ADDR_W-1:0] we_addr = '0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // RAM with one-cycle read latency plus event counters for writes, responses and acceptances.
  always @(posedge clock) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
      we_addr       <= mem_addr;
    end
    mem_rdata <= ram[mem_addr];
    if (rsp_valid) rsp_count <= rsp_count + 1;
    if (req_valid && req_ready) acc_count <= acc_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int guard;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clock);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          we0;
  int          rsp0;
  int          acc0;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);

    we0 = we_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    check("sw_lat", lat, 2);
    check("sw_we_pulses", we_count - we0, 1);
    check("sw_we_addr", {18'b0, we_addr}, 32'd4);
    check("sw_ram", ram[4], 32'hDEADBEEF);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", {31'b0, er}, 32'd0);

    we0 = we_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    check("lw_lat", lat, 3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_no_we", we_count - we0, 0);

    we0 = we_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, rd, er);
    check("sb_lat", lat, 4);
    check("sb_ram", ram[4], 32'hDEAD55EF);
    check("sb_we_pulses", we_count - we0, 1);

    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er);
    check("lbu_11", rd, 32'h00000055);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80011234, lat, rd, er);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er);
    check("lh_12", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er);
    check("lhu_12", rd, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er);
    check("lh_10", rd, 32'h00001234);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
    check("lb_13", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
    check("lbu_13", rd, 32'h00000080);

    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1111ABCD, lat, rd, er);
    check("sh_lat", lat, 4);
    check("sh_ram", ram[4], 32'hABCD1234);

    do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, lat, rd, er);
    check("sz11_lat", lat, 3);
    check("sz11_rdata", rd, 32'hABCD1234);

    do_req(1'b0, 2'b10, 1'b0, 32'h00010010, 32'h0, lat, rd, er);
    check("hi_addr_rdata", rd, 32'hABCD1234);

    we0 = we_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_err", {31'b0, er}, 32'd1);
    check("mis_rdata", rd, 32'h0);
`else
    check("mis_lat", lat, 3);
    check("mis_err", {31'b0, er}, 32'd0);
    check("mis_rdata", rd, 32'hABCD1234);
`endif
    check("mis_no_we", we_count - we0, 0);

    we0  = we_count;
    rsp0 = rsp_count;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'h77;
    req_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_mem_we", {31'b0, mem_we}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'h0);
    repeat (4) @(negedge clock);
    check("abort_no_write", we_count - we0, 0);
    check("abort_no_rsp", rsp_count - rsp0, 0);
    check("abort_ram", ram[4], 32'hABCD1234);

    acc0 = acc_count;
    rsp0 = rsp_count;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(negedge clock);
    check("busy_ready", {31'b0, req_ready}, 32'd0);
    repeat (7) @(negedge clock);
    req_valid = 1'b0;
    check("held_accepts", acc_count - acc0, 2);
    check("held_rsps", rsp_count - rsp0, 2);
    check("held_rdata", rsp_rdata, 32'hABCD1234);
    repeat (3) @(negedge clock);
    check("held_no_extra", acc_count - acc0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
